// File: rtl/step_down_counter_pkg.sv
// step_down_counter_pkg: shared FSM state encoding and default counter width
// for the step_down_counter block.
package step_down_counter_pkg;

   // Default counter / load width in bits.
   localparam int unsigned DefaultWidth = 3;

   // Sequencer states: waiting for a load, counting down, completion pulse.
   typedef enum logic [1:0] {
      StIdle = 2'b00,
      StRun  = 2'b01,
      StDone = 2'b10
   } state_e;

endpackage : step_down_counter_pkg

// File: rtl/step_down_counter_decrementer.sv
// step_down_counter_decrementer: combinational WIDTH-bit subtract-by-one.
// Callers guarantee the input is non-zero when the result is used.
module step_down_counter_decrementer #(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] in_val,
   output logic [WIDTH-1:0] out_val
);

   // Plain modular decrement; wrap-around is never selected by the counter.
   always_comb begin
      out_val = in_val - WIDTH'(1);
   end

endmodule : step_down_counter_decrementer

// File: rtl/step_down_counter.sv
// step_down_counter: loadable down-counter sequenced by an IDLE/RUN/DONE FSM.
// A start in IDLE loads load_val, RUN steps down on enable, DONE emits a
// one-cycle done pulse. Define STEP_DOWN_COUNTER_ABORT_EN to add an abort
// input that returns RUN to IDLE without a done pulse.
module step_down_counter
   import step_down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] load_val,
   input  logic             enable,
`ifdef STEP_DOWN_COUNTER_ABORT_EN
   input  logic             abort,
`endif
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             last,
   output logic             done
);

   state_e           r_state;
   logic [WIDTH-1:0] r_count;
   logic             r_busy;
   logic             r_done;
   logic [WIDTH-1:0] w_count_dec;
   logic             w_count_is_one;

   step_down_counter_decrementer #(
      .WIDTH (WIDTH)
   ) u_decrementer (
      .in_val  (r_count),
      .out_val (w_count_dec)
   );

   // Count of one means the next enabled step finishes the run.
   always_comb begin
      w_count_is_one = (r_count == WIDTH'(1));
   end

   // Sequencer FSM; busy/done are registered alongside the state they decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_count <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
`ifdef STEP_DOWN_COUNTER_ABORT_EN
               if (!abort && start) begin
`else
               if (start) begin
`endif
                  if (load_val != '0) begin
                     r_count <= load_val;
                     r_state <= StRun;
                     r_busy  <= 1'b1;
                  end else begin
                     // Zero-length run skips RUN entirely.
                     r_count <= '0;
                     r_state <= StDone;
                     r_done  <= 1'b1;
                  end
               end
            end
            StRun: begin
`ifdef STEP_DOWN_COUNTER_ABORT_EN
               if (abort) begin
                  // Abandon the run with count frozen and no done pulse.
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else if (enable) begin
`else
               if (enable) begin
`endif
                  r_count <= w_count_dec;
                  if (w_count_is_one) begin
                     r_state <= StDone;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            StDone: begin
               r_state <= StIdle;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   // Output mapping; last flags the pending final step.
   always_comb begin
      count = r_count;
      busy  = r_busy;
      done  = r_done;
      last  = r_busy && w_count_is_one;
   end

endmodule : step_down_counter

// File: tb/tb_step_down_counter.sv
// tb_step_down_counter: directed stimulus with a behavioural model checked
// every cycle, plus literal expectations for the documented sequences.
module tb_step_down_counter;

   localparam int unsigned W = 3;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] load_val;
   logic         enable;
`ifdef STEP_DOWN_COUNTER_ABORT_EN
   logic         abort;
`endif
   logic [W-1:0] count;
   logic         busy;
   logic         last;
   logic         done;

   int checks   = 0;
   int failures = 0;

   // Model: remaining steps, whether a run is active, whether done is showing.
   int m_count  = 0;
   bit m_active = 0;
   bit m_done   = 0;

   step_down_counter #(
      .WIDTH (W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .load_val (load_val),
      .enable   (enable),
`ifdef STEP_DOWN_COUNTER_ABORT_EN
      .abort    (abort),
`endif
      .count    (count),
      .busy     (busy),
      .last     (last),
      .done     (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_count  = 0;
      m_active = 0;
      m_done   = 0;
   endtask

   // Advance the model by one clock edge using the inputs present at that edge.
   task automatic model_step();
`ifdef STEP_DOWN_COUNTER_ABORT_EN
      bit ab;
      ab = abort;
`else
      bit ab;
      ab = 1'b0;
`endif
      if (m_done) begin
         m_done = 0;
      end else if (m_active) begin
         if (ab) begin
            m_active = 0;
         end else if (enable) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
               m_active = 0;
               m_done   = 1;
            end
         end
      end else if (start && !ab) begin
         m_count = int'(load_val);
         if (m_count == 0) m_done = 1;
         else m_active = 1;
      end
   endtask

   // Compare DUT against the model on every falling edge outside reset.
   always @(negedge clk) begin
      if (!rst) begin
         check("model_count", int'(count), m_count);
         check("model_busy", int'(busy), int'(m_active));
         check("model_last", int'(last), int'(m_active && (m_count == 1)));
         check("model_done", int'(done), int'(m_done));
      end
   end

   // One clock: model follows the rising edge, stimulus resumes on the falling edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic lit(input int c, input bit b, input bit l, input bit d);
      check("lit_count", int'(count), c);
      check("lit_busy", int'(busy), int'(b));
      check("lit_last", int'(last), int'(l));
      check("lit_done", int'(done), int'(d));
   endtask

   task automatic do_start(input int val);
      start    = 1'b1;
      load_val = W'(val);
      tick();
      start    = 1'b0;
      load_val = '0;
   endtask

   initial begin
      int exp_c [6];
      rst      = 1'b1;
      start    = 1'b0;
      load_val = '0;
      enable   = 1'b0;
`ifdef STEP_DOWN_COUNTER_ABORT_EN
      abort    = 1'b0;
`endif
      model_reset();
      @(negedge clk);
      lit(0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;

      // load 5, enable held: 5,4,3,2,1,0 with done alongside the 0
      enable = 1'b1;
      do_start(5);
      lit(5, 1, 0, 0);
      exp_c = '{4, 3, 2, 1, 0, 0};
      for (int i = 0; i < 4; i++) begin
         tick();
         lit(exp_c[i], 1, exp_c[i] == 1, 0);
      end
      tick();
      lit(0, 0, 0, 1);
      tick();
      lit(0, 0, 0, 0);

      // enable ignored in IDLE
      tick();
      tick();
      lit(0, 0, 0, 0);

      // load 3, enable pattern 1,0,0,1,1 -> 2,2,2,1,0
      enable = 1'b0;
      do_start(3);
      lit(3, 1, 0, 0);
      exp_c = '{2, 2, 2, 1, 0, 0};
      for (int i = 0; i < 5; i++) begin
         enable = (i == 0 || i >= 3);
         tick();
         check("tog_count", int'(count), exp_c[i]);
         check("tog_done", int'(done), int'(i == 4));
      end
      enable = 1'b0;
      tick();
      lit(0, 0, 0, 0);

      // zero load: straight to DONE, busy never high
      enable = 1'b1;
      do_start(0);
      lit(0, 0, 0, 1);
      tick();
      lit(0, 0, 0, 0);

      // load 7, two decrements, then asynchronous reset mid-run
      do_start(7);
      tick();
      tick();
      lit(5, 1, 0, 0);
      #1 rst = 1'b1;
      model_reset();
      #1;
      lit(0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      do_start(2);
      lit(2, 1, 0, 0);
      tick();
      lit(1, 1, 1, 0);
      tick();
      lit(0, 0, 0, 1);
      tick();

      // start during RUN is ignored
      do_start(4);
      lit(4, 1, 0, 0);
      start    = 1'b1;
      load_val = W'(1);
      tick();
      lit(3, 1, 0, 0);
      tick();
      start    = 1'b0;
      lit(2, 1, 0, 0);
      tick();
      lit(1, 1, 1, 0);
      tick();
      lit(0, 0, 0, 1);
      tick();

      // full-range load of 7 with a wait state inserted
      do_start(7);
      enable = 1'b0;
      tick();
      lit(7, 1, 0, 0);
      enable = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      lit(0, 0, 0, 1);
      tick();

`ifdef STEP_DOWN_COUNTER_ABORT_EN
      // abort at count 4: back to IDLE, count held, no done
      do_start(6);
      tick();
      tick();
      lit(4, 1, 0, 0);
      abort = 1'b1;
      tick();
      lit(4, 0, 0, 0);
      start    = 1'b1;
      load_val = W'(3);
      tick();
      lit(4, 0, 0, 0);
      abort = 1'b0;
      start = 1'b0;
      tick();
      lit(4, 0, 0, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_step_down_counter
